mp4_data_array_nway: RTL and testbench

- Parametrised multi-way cache data array; successor to the single-way 128-bit SRAM macro model.
- Holds WAYS ways of RAM_DEPTH lines each and reads all ways in parallel for tag-compare muxing.
- Writes one or more ways with byte-granular masking.
- Adds a post-reset initialisation sweep, a ready indication, write-first read-during-write, and a registered output-valid strobe, all on a single rising-edge clock with no negedge logic.

---
 rtl/mp4_data_array_nway.sv | 120 ++++++++++++
 tb/tb_mp4_data_array_nway.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mp4_data_array_nway.sv
// Multi-way cache data array with a post-reset init sweep, byte-masked writes,
// write-first parallel read of every way, and a registered output-valid strobe.
module mp4_data_array_nway #(
  parameter int                    WAYS       = 4,
  parameter int                    DATA_WIDTH = 256,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    NUM_WMASKS = DATA_WIDTH / 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic                       csb,
  input  logic                       web,
  input  logic [WAYS-1:0]            way_sel,
  input  logic [NUM_WMASKS-1:0]      wmask,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic [WAYS*DATA_WIDTH-1:0] dout,
  output logic                       dout_valid
);

  localparam int                    RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     init_ptr_q;
  logic                      ready_q;
  logic                      dout_valid_q;
  logic [WAYS*DATA_WIDTH-1:0] dout_q;
  logic [WAYS*DATA_WIDTH-1:0] dout_d;

  logic [DATA_WIDTH-1:0]     mem_q       [WAYS][RAM_DEPTH];
  logic [DATA_WIDTH-1:0]     line_rd     [WAYS];
  logic [DATA_WIDTH-1:0]     line_merged [WAYS];
  logic [DATA_WIDTH-1:0]     mem_wdata   [WAYS];
  logic [WAYS-1:0]           mem_we;
  logic [ADDR_WIDTH-1:0]     mem_waddr;

  logic                      sweep;
  logic                      access_ok;
  logic                      wr_ok;

  assign sweep     = (state_q == ST_INIT);
  assign access_ok = (state_q == ST_READY) && !csb;
  assign wr_ok     = access_ok && !web;

  // Merge din into the addressed line of every way; the merged line is both
  // what gets written and what a written way presents on dout (write-first).
  // NOTE: combinational logic uses blocking '=' with every output defaulted
  // first, so no latch can be inferred.
  always_comb begin
    mem_waddr = sweep ? init_ptr_q : addr;
    mem_we    = '0;
    dout_d    = '0;
    for (int w = 0; w < WAYS; w++) begin
      line_rd[w]     = mem_q[w][addr];
      line_merged[w] = line_rd[w];
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask[i]) line_merged[w][8*i +: 8] = din[8*i +: 8];
      end
      mem_we[w]    = sweep || (wr_ok && way_sel[w]);
      mem_wdata[w] = sweep ? INIT_VALUE : line_merged[w];
      dout_d[w*DATA_WIDTH +: DATA_WIDTH] =
        (wr_ok && way_sel[w]) ? line_merged[w] : line_rd[w];
    end
  end

  // NOTE: the storage array is deliberately not reset; the init sweep gives it
  // defined contents, and reset only blocks any write pending at that edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++) begin
        if (mem_we[w]) mem_q[w][mem_waddr] <= mem_wdata[w];
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      ready_q      <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_ptr_q   <= init_ptr_q + 1'b1;
          dout_valid_q <= 1'b0;
          if (init_ptr_q == LAST_PTR) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          dout_valid_q <= !csb;
          if (!csb) dout_q <= dout_d;
        end
        default: begin
          state_q    <= ST_INIT;
          init_ptr_q <= '0;
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mp4_data_array_nway.sv
// Self-checking bench for mp4_data_array_nway (2 ways x 32 bits x 8 sets)
// against a per-way, per-set array model of the contents.
module tb_mp4_data_array_nway;

  localparam int WAYS  = 2;
  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int NM    = DW / 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                ready;
  logic                csb;
  logic                web;
  logic [WAYS-1:0]     way_sel;
  logic [NM-1:0]       wmask;
  logic [AW-1:0]       addr;
  logic [DW-1:0]       din;
  logic [WAYS*DW-1:0]  dout;
  logic                dout_valid;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]      model [WAYS][DEPTH];
  logic [WAYS*DW-1:0] last_exp;

  mp4_data_array_nway #(
    .WAYS       (WAYS),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .csb        (csb),
    .web        (web),
    .way_sel    (way_sel),
    .wmask      (wmask),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [WAYS*DW-1:0] model_line(input int a);
    logic [WAYS*DW-1:0] r;
    r = '0;
    for (int w = 0; w < WAYS; w++) r[w*DW +: DW] = model[w][a];
    return r;
  endfunction

  task automatic model_clear;
    for (int w = 0; w < WAYS; w++)
      for (int a = 0; a < DEPTH; a++) model[w][a] = '0;
  endtask

  // One accepted access; the model is updated first so a write is seen on dout
  // at the same edge.
  task automatic access(input string name, input logic we, input logic [WAYS-1:0] ws,
                        input logic [NM-1:0] wm, input int a, input logic [DW-1:0] d);
    csb = 1'b0; web = ~we; way_sel = ws; wmask = wm; addr = AW'(a); din = d;
    @(posedge clk); #1;
    if (we) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ws[w]) begin
          for (int b = 0; b < NM; b++)
            if (wm[b]) model[w][a][8*b +: 8] = d[8*b +: 8];
        end
      end
    end
    last_exp = model_line(a);
    total++;
    if (dout_valid !== 1'b1) begin
      bad++; $display("FAIL %s valid: got %b want 1", name, dout_valid);
    end
    total++;
    if (dout !== last_exp) begin
      bad++; $display("FAIL %s dout: got %h want %h", name, dout, last_exp);
    end
  endtask

  task automatic idle(input string name);
    csb = 1'b1; web = 1'b1; way_sel = '0; wmask = '0;
    @(posedge clk); #1;
    total++;
    if (dout_valid !== 1'b0) begin
      bad++; $display("FAIL %s valid: got %b want 0", name, dout_valid);
    end
    total++;
    if (dout !== last_exp) begin
      bad++; $display("FAIL %s hold: got %h want %h", name, dout, last_exp);
    end
  endtask

  // Eight sweep edges after rst drops; ready must rise exactly on the 8th.
  task automatic sweep_check(input string name);
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk); #1;
      total++;
      if (ready !== (k == DEPTH)) begin
        bad++; $display("FAIL %s ready edge %0d: got %b want %b", name, k, ready, k == DEPTH);
      end
      total++;
      if (dout_valid !== 1'b0 || dout !== '0) begin
        bad++; $display("FAIL %s init out edge %0d: got valid=%b dout=%h want 0/0", name, k, dout_valid, dout);
      end
    end
    model_clear();
    last_exp = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; csb = 1'b0; web = 1'b1; way_sel = '0; wmask = '0; addr = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0 || dout_valid !== 1'b0 || dout !== '0) begin
      bad++; $display("FAIL reset: got ready=%b valid=%b dout=%h want 0/0/0", ready, dout_valid, dout);
    end
    rst = 1'b0;
    sweep_check("reset");
    for (int a = 0; a < DEPTH; a++) access("init_read", 1'b0, '0, '0, a, '0);
  endtask

  task automatic test_masked_write;
    access("mask_wr", 1'b1, 2'b01, 4'b0101, 3, 32'hAABBCCDD);
    access("mask_rd", 1'b0, 2'b00, 4'b0000, 3, 32'h0);
    total++;
    if (dout !== 64'h00000000_00BB00DD) begin
      bad++; $display("FAIL mask_abs: got %h want 0000000000bb00dd", dout);
    end
  endtask

  task automatic test_write_first;
    access("wf_wr", 1'b1, 2'b11, 4'hF, 5, 32'h12345678);
    total++;
    if (dout !== 64'h12345678_12345678) begin
      bad++; $display("FAIL wf_abs: got %h want 1234567812345678", dout);
    end
    access("wf_rd", 1'b0, 2'b00, 4'h0, 5, 32'h0);
  endtask

  task automatic test_back_to_back;
    access("b2b_wr", 1'b1, 2'b10, 4'hF, 1, 32'hCAFEF00D);
    access("b2b_rd", 1'b0, 2'b00, 4'h0, 1, 32'h0);
    total++;
    if (dout !== 64'hCAFEF00D_00000000) begin
      bad++; $display("FAIL b2b_abs: got %h want cafef00d00000000", dout);
    end
    idle("b2b_idle");
    idle("b2b_idle2");
  endtask

  task automatic test_no_way;
    access("noway_wr", 1'b1, 2'b00, 4'hF, 2, 32'hDEADBEEF);
    access("nomask_wr", 1'b1, 2'b11, 4'h0, 2, 32'hDEADBEEF);
    access("noway_rd", 1'b0, 2'b00, 4'h0, 2, 32'h0);
    total++;
    if (dout !== 64'h0) begin
      bad++; $display("FAIL noway_abs: got %h want 0", dout);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) idle("rnd_idle");
      else access("rnd", $urandom_range(0, 1) == 1, WAYS'($urandom),
                  NM'($urandom), $urandom_range(0, DEPTH-1), $urandom);
    end
  endtask

  task automatic test_reset_mid_write;
    access("pop_wr", 1'b1, 2'b11, 4'hF, 4, 32'h5A5AA5A5);
    csb = 1'b0; web = 1'b0; way_sel = 2'b11; wmask = 4'hF; addr = 3'd6; din = 32'h77777777;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready !== 1'b0 || dout_valid !== 1'b0 || dout !== '0) begin
      bad++; $display("FAIL midrst: got ready=%b valid=%b dout=%h want 0/0/0", ready, dout_valid, dout);
    end
    rst = 1'b0;
    sweep_check("midrst");
    access("midrst_rd4", 1'b0, '0, '0, 4, '0);
    access("midrst_rd6", 1'b0, '0, '0, 6, '0);
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_write_first();
    test_back_to_back();
    test_no_way();
    test_random();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
